// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master port (AW/W/B) between
// NUM_REQ requesters. The grant is taken at AW arbitration and held until
// the B handshake. W beats are counted, and PROT_ERR latches a burst that
// runs past MAX_BEATS without WLAST.
module axi_wr_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int SIZE_W    = 2,
   parameter int BURST_W   = 2,
   parameter int RESP_W    = 2,
   parameter int MAX_BEATS = 256
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic [NUM_REQ-1:0]         S_AWVALID,
   output logic [NUM_REQ-1:0]         S_AWREADY,
   input  logic [NUM_REQ*ADDR_W-1:0]  S_AWADDR,
   input  logic [NUM_REQ*SIZE_W-1:0]  S_AWSIZE,
   input  logic [NUM_REQ*BURST_W-1:0] S_AWBURST,
   input  logic [NUM_REQ-1:0]         S_WVALID,
   input  logic [NUM_REQ-1:0]         S_WLAST,
   input  logic [NUM_REQ*DATA_W-1:0]  S_WDATA,
   output logic [NUM_REQ-1:0]         S_WREADY,
   output logic [NUM_REQ-1:0]         S_BVALID,
   output logic [RESP_W-1:0]          S_BRESP,
   input  logic [NUM_REQ-1:0]         S_BREADY,
   output logic                       M_AWVALID,
   output logic [ADDR_W-1:0]          M_AWADDR,
   output logic [SIZE_W-1:0]          M_AWSIZE,
   output logic [BURST_W-1:0]         M_AWBURST,
   input  logic                       M_AWREADY,
   output logic                       M_WVALID,
   output logic                       M_WLAST,
   output logic [DATA_W-1:0]          M_WDATA,
   input  logic                       M_WREADY,
   input  logic                       M_BVALID,
   input  logic [RESP_W-1:0]          M_BRESP,
   output logic                       M_BREADY,
   output logic [NUM_REQ-1:0]         GRANT,
   output logic                       BUSY,
   output logic                       PROT_ERR
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   gnt_q;
   logic [IDX_W-1:0]   last_q;
   logic [IDX_W-1:0]   pick;
   logic               any_req;
   logic               aw_done_q, w_done_q;
   logic [CNT_W-1:0]   beat_cnt;
   logic               prot_err_q;
   logic               aw_hs, w_hs, b_hs;

   // Round-robin pick: first requester after last_q, wrapping around.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      any_req = 1'b0;
      pick    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!any_req && S_AWVALID[IDX_W'((int'(last_q) + k) % NUM_REQ)]) begin
            any_req = 1'b1;
            pick    = IDX_W'((int'(last_q) + k) % NUM_REQ);
         end
      end
   end

   // Next-state logic and channel routing for the granted requester.
   always_comb begin
      state_d   = state_q;
      M_AWVALID = 1'b0;
      M_AWADDR  = '0;
      M_AWSIZE  = '0;
      M_AWBURST = '0;
      M_WVALID  = 1'b0;
      M_WLAST   = 1'b0;
      M_WDATA   = '0;
      M_BREADY  = 1'b0;
      S_AWREADY = '0;
      S_WREADY  = '0;
      S_BVALID  = '0;
      S_BRESP   = '0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
      b_hs      = 1'b0;

      if (state_q != ST_IDLE) begin
         M_AWADDR  = S_AWADDR[int'(gnt_q)*ADDR_W +: ADDR_W];
         M_AWSIZE  = S_AWSIZE[int'(gnt_q)*SIZE_W +: SIZE_W];
         M_AWBURST = S_AWBURST[int'(gnt_q)*BURST_W +: BURST_W];
         M_WDATA   = S_WDATA[int'(gnt_q)*DATA_W +: DATA_W];
      end

      case (state_q)
         ST_IDLE: begin
            if (any_req) state_d = ST_XFER;
         end
         ST_XFER: begin
            M_AWVALID        = S_AWVALID[gnt_q] & ~aw_done_q;
            S_AWREADY[gnt_q] = M_AWREADY & ~aw_done_q;
            M_WVALID         = S_WVALID[gnt_q] & ~w_done_q;
            M_WLAST          = S_WLAST[gnt_q];
            S_WREADY[gnt_q]  = M_WREADY & ~w_done_q;
            aw_hs            = M_AWVALID & M_AWREADY;
            w_hs             = M_WVALID & M_WREADY;
            if ((aw_done_q | aw_hs) && (w_done_q | (w_hs & M_WLAST)))
               state_d = ST_RESP;
         end
         ST_RESP: begin
            M_BREADY        = S_BREADY[gnt_q];
            S_BVALID[gnt_q] = M_BVALID;
            S_BRESP         = M_BRESP;
            b_hs            = M_BVALID & M_BREADY;
            if (b_hs) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, grant, handshake flags, beat counter and sticky overrun flag.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         last_q     <= IDX_W'(NUM_REQ - 1);
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         beat_cnt   <= '0;
         prot_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (any_req) gnt_q <= pick;
            end
            ST_XFER: begin
               if (aw_hs) aw_done_q <= 1'b1;
               if (w_hs) begin
                  if (M_WLAST) w_done_q <= 1'b1;
                  if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
                  if (beat_cnt == CNT_W'(MAX_BEATS - 1) && !M_WLAST)
                     prot_err_q <= 1'b1;
               end
            end
            ST_RESP: begin
               if (b_hs) begin
                  last_q    <= gnt_q;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  beat_cnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs: one-hot owner while busy, zero when idle.
   always_comb begin
      GRANT = '0;
      if (state_q != ST_IDLE) GRANT[gnt_q] = 1'b1;
      BUSY     = (state_q != ST_IDLE);
      PROT_ERR = prot_err_q;
   end

endmodule
